// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the pipelined ALU control block: ALUOp classes, ALU control codes,
// funct7 classes and FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_JUMP   = 2'b11;

    localparam logic [4:0] CODE_AND  = 5'b00000;
    localparam logic [4:0] CODE_OR   = 5'b00001;
    localparam logic [4:0] CODE_ADD  = 5'b00010;
    localparam logic [4:0] CODE_BNE  = 5'b00011;
    localparam logic [4:0] CODE_SLL  = 5'b00100;
    localparam logic [4:0] CODE_SRL  = 5'b00101;
    localparam logic [4:0] CODE_SUB  = 5'b00110;
    localparam logic [4:0] CODE_BGE  = 5'b00111;
    localparam logic [4:0] CODE_BLT  = 5'b01000;
    localparam logic [4:0] CODE_XOR  = 5'b01001;
    localparam logic [4:0] CODE_SRA  = 5'b01010;
    localparam logic [4:0] CODE_SLT  = 5'b01011;
    localparam logic [4:0] CODE_SLTU = 5'b01100;
    localparam logic [4:0] CODE_BLTU = 5'b01101;
    localparam logic [4:0] CODE_BGEU = 5'b01110;
    localparam logic [1:0] CODE_MEXT_PREFIX = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    // Base-encoding arithmetic/logic op selected by funct3 alone.
    function automatic logic [4:0] arith_code(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_code = CODE_ADD;
            3'b001:  arith_code = CODE_SLL;
            3'b010:  arith_code = CODE_SLT;
            3'b011:  arith_code = CODE_SLTU;
            3'b100:  arith_code = CODE_XOR;
            3'b101:  arith_code = CODE_SRL;
            3'b110:  arith_code = CODE_OR;
            default: arith_code = CODE_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7 decoder. RV32M decoding is present only when
// ALU_CONTROL_PIPE_MEXT_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_src_imm,
    output logic [4:0] code,
    output logic       illegal,
    output logic       is_mul,
    output logic       is_div
);

    logic imm_plain;

    // Immediates only carry a funct7 field for the shift encodings.
    assign imm_plain = alu_src_imm && (funct3 != 3'b001) && (funct3 != 3'b101);

    always_comb begin
        code    = CODE_ADD;
        illegal = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (ALUOp)
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000:  code = CODE_SUB;
                    3'b001:  code = CODE_BNE;
                    3'b100:  code = CODE_BLT;
                    3'b101:  code = CODE_BGE;
                    3'b110:  code = CODE_BLTU;
                    3'b111:  code = CODE_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            ALUOP_ARITH: begin
                if (imm_plain || funct7 == F7_BASE) begin
                    code = arith_code(funct3);
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  code = CODE_SUB;
                        3'b101:  code = CODE_SRA;
                        default: illegal = 1'b1;
                    endcase
                end
`ifdef ALU_CONTROL_PIPE_MEXT_EN
                else if (funct7 == F7_MEXT && !alu_src_imm) begin
                    code   = {CODE_MEXT_PREFIX, funct3};
                    is_mul = !funct3[2];
                    is_div = funct3[2];
                end
`endif
                else begin
                    illegal = 1'b1;
                end
            end
            default: code = CODE_ADD;
        endcase
    end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with valid/ready handshake. Define ALU_CONTROL_PIPE_MEXT_EN
// to enable multi-cycle RV32M ops (WAIT state with latency counter).
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              alu_src_imm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUcontrol,
    output logic              illegal,
    output logic              busy
);

    state_t     state;
    state_t     next_state;
    logic [4:0] dec_code;
    logic       dec_illegal;
    logic       dec_is_mul;
    logic       dec_is_div;
    logic       accept;
    logic       needs_wait;
    logic       wait_done;

    alu_ctrl_decode u_decode (
        .ALUOp       (ALUOp),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_src_imm (alu_src_imm),
        .code        (dec_code),
        .illegal     (dec_illegal),
        .is_mul      (dec_is_mul),
        .is_div      (dec_is_div)
    );

    assign accept = in_valid && in_ready && !flush;

`ifdef ALU_CONTROL_PIPE_MEXT_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] start_count;

    // A latency of one collapses to the single-cycle path and never enters WAIT.
    assign needs_wait  = (dec_is_mul && MUL_LAT > 1) || (dec_is_div && DIV_LAT > 1);
    assign start_count = dec_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    assign wait_done   = (counter == CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (flush) begin
            counter <= '0;
        end else if (accept && needs_wait) begin
            counter <= start_count;
        end else if (state == ST_WAIT && counter != '0) begin
            counter <= counter - CNT_W'(1);
        end
    end
`else
    localparam int unused_lat = MUL_LAT + DIV_LAT;

    logic unused_dec;

    assign unused_dec = dec_is_mul | dec_is_div;
    assign needs_wait = 1'b0;
    assign wait_done  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over everything, including a request arriving in the same cycle.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) next_state = needs_wait ? ST_WAIT : ST_VALID;
                end
                ST_WAIT: begin
                    if (wait_done) next_state = ST_VALID;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (accept) next_state = needs_wait ? ST_WAIT : ST_VALID;
                        else        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_VALID && out_ready);
        out_valid = (state == ST_VALID);
`ifdef ALU_CONTROL_PIPE_MEXT_EN
        busy      = (state == ST_WAIT);
`else
        busy      = 1'b0;
`endif
    end

    // Result is captured at acceptance and held through WAIT and any stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ALUcontrol <= CTRL_W'(CODE_ADD);
            illegal    <= 1'b0;
        end else if (accept) begin
            ALUcontrol <= CTRL_W'(dec_code);
            illegal    <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: hand-written handshake/latency sequences plus a
// table of decode vectors checked through an expected-result queue.
module tb_alu_control_pipe;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_src_imm;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] ALUcontrol;
    logic       illegal;
    logic       busy;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       imm;
        logic [4:0] code;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [4:0] code;
        logic       ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    alu_control_pipe #(
        .CTRL_W  (5),
        .MUL_LAT (3),
        .DIV_LAT (32)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOp       (ALUOp),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_src_imm (alu_src_imm),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUcontrol  (ALUcontrol),
        .illegal     (illegal),
        .busy        (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic imm, input logic fl);
        in_valid    = v;
        ALUOp       = op;
        funct3      = f3;
        funct7      = f7;
        alu_src_imm = imm;
        flush       = fl;
    endtask

    task automatic addVec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic imm, input logic [4:0] code, input logic ill);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.imm = imm; v.code = code; v.ill = ill;
        vecs.push_back(v);
    endtask

    // One cycle of the scoreboard flow; entered and left just after a falling edge.
    task automatic sbStep(input logic [4:0] ecode, input logic eill, output logic accepted);
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_code", ALUcontrol, e.code);
                checkOutput("sb_illegal", illegal, e.ill);
            end
        end
        accepted = in_valid && in_ready && !flush;
        if (accepted) begin
            e.code = ecode;
            e.ill  = eill;
            sb.push_back(e);
        end
        @(negedge clock);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        int   tries;
        logic rose;

        reset_n   = 1'b0;
        out_ready = 1'b1;
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_alucontrol", ALUcontrol, 5'b00010);
        checkOutput("reset_illegal", illegal, 0);
        checkOutput("reset_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("idle_in_ready", in_ready, 1);

        // Accept SUB with the consumer stalled, then hold for five cycles.
        out_ready = 1'b0;
        applyStimulus(1, 2'b10, 3'b000, 7'b0100000, 0, 0);
        @(negedge clock);
        applyStimulus(1, 2'b01, 3'b110, 7'b0, 0, 0);
        #1;
        checkOutput("sub_out_valid", out_valid, 1);
        checkOutput("sub_code", ALUcontrol, 5'b00110);
        checkOutput("sub_illegal", illegal, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1;
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_code", ALUcontrol, 5'b00110);
            checkOutput("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_same_cycle_ready", in_ready, 1);
        @(negedge clock);
        applyStimulus(1, 2'b01, 3'b111, 7'b0, 0, 0);
        #1;
        checkOutput("after_stall_valid", out_valid, 1);
        checkOutput("after_stall_bltu", ALUcontrol, 5'b01101);
        @(negedge clock);
        applyStimulus(1, 2'b01, 3'b010, 7'b0, 0, 0);
        #1;
        checkOutput("b2b_bgeu", ALUcontrol, 5'b01110);
        checkOutput("b2b_bgeu_valid", out_valid, 1);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        #1;
        checkOutput("br010_code", ALUcontrol, 5'b00010);
        checkOutput("br010_illegal", illegal, 1);
        @(negedge clock);
        #1;
        checkOutput("drain_to_idle", out_valid, 0);

        // Flush while VALID with a request arriving: both dropped, code retained.
        out_ready = 1'b0;
        applyStimulus(1, 2'b10, 3'b100, 7'b0, 0, 0);
        @(negedge clock);
        #1;
        checkOutput("xor_code", ALUcontrol, 5'b01001);
        out_ready = 1'b1;
        applyStimulus(1, 2'b10, 3'b110, 7'b0, 0, 1);
        @(negedge clock);
        applyStimulus(1, 2'b10, 3'b111, 7'b0, 0, 1);
        #1;
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_retain_code", ALUcontrol, 5'b01001);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        #1;
        checkOutput("flush_idle_drop", out_valid, 0);
        checkOutput("flush_idle_code", ALUcontrol, 5'b01001);

`ifdef ALU_CONTROL_PIPE_MEXT_EN
        applyStimulus(1, 2'b10, 3'b100, 7'b0000001, 0, 0);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        for (int k = 1; k <= 31; k++) begin
            #1;
            checkOutput("div_busy", busy, 1);
            checkOutput("div_in_ready", in_ready, 0);
            checkOutput("div_out_valid_early", out_valid, 0);
            @(negedge clock);
        end
        #1;
        checkOutput("div_out_valid", out_valid, 1);
        checkOutput("div_code", ALUcontrol, 5'b10100);
        checkOutput("div_busy_done", busy, 0);
        @(negedge clock);

        applyStimulus(1, 2'b10, 3'b000, 7'b0000001, 0, 0);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        #1;
        checkOutput("mul_wait1", out_valid, 0);
        @(negedge clock);
        #1;
        checkOutput("mul_wait2", busy, 1);
        @(negedge clock);
        #1;
        checkOutput("mul_out_valid", out_valid, 1);
        checkOutput("mul_code", ALUcontrol, 5'b10000);
        @(negedge clock);

        applyStimulus(1, 2'b10, 3'b101, 7'b0000001, 0, 0);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        checkOutput("div_flush_busy", busy, 0);
        checkOutput("div_flush_in_ready", in_ready, 1);
        rose = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (out_valid) rose = 1'b1;
        end
        checkOutput("div_flush_never_valid", rose, 0);

        applyStimulus(1, 2'b10, 3'b110, 7'b0000001, 0, 0);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        repeat (5) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_busy", busy, 0);
        checkOutput("areset_out_valid", out_valid, 0);
        checkOutput("areset_code", ALUcontrol, 5'b00010);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
`else
        applyStimulus(1, 2'b10, 3'b000, 7'b0000001, 0, 0);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        #1;
        checkOutput("nomext_out_valid", out_valid, 1);
        checkOutput("nomext_code", ALUcontrol, 5'b00010);
        checkOutput("nomext_illegal", illegal, 1);
        checkOutput("nomext_busy", busy, 0);
        @(negedge clock);

        out_ready = 1'b0;
        applyStimulus(1, 2'b10, 3'b111, 7'b0, 0, 0);
        @(negedge clock);
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", out_valid, 0);
        checkOutput("areset_code", ALUcontrol, 5'b00010);
        checkOutput("areset_illegal", illegal, 0);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
`endif

        addVec(2'b10, 3'b000, 7'b0100000, 0, 5'b00110, 0);
        addVec(2'b10, 3'b000, 7'b0100000, 1, 5'b00010, 0);
        addVec(2'b10, 3'b101, 7'b0100000, 1, 5'b01010, 0);
        addVec(2'b01, 3'b110, 7'b0000000, 0, 5'b01101, 0);
        addVec(2'b01, 3'b111, 7'b0000000, 0, 5'b01110, 0);
        addVec(2'b01, 3'b010, 7'b0000000, 0, 5'b00010, 1);
        addVec(2'b01, 3'b011, 7'b0000000, 0, 5'b00010, 1);
        addVec(2'b01, 3'b000, 7'b0000000, 0, 5'b00110, 0);
        addVec(2'b01, 3'b001, 7'b0000000, 0, 5'b00011, 0);
        addVec(2'b01, 3'b100, 7'b0000000, 0, 5'b01000, 0);
        addVec(2'b01, 3'b101, 7'b0000000, 0, 5'b00111, 0);
        addVec(2'b00, 3'b101, 7'b0100000, 0, 5'b00010, 0);
        addVec(2'b11, 3'b010, 7'b1111111, 1, 5'b00010, 0);
        addVec(2'b10, 3'b000, 7'b0000000, 0, 5'b00010, 0);
        addVec(2'b10, 3'b001, 7'b0000000, 0, 5'b00100, 0);
        addVec(2'b10, 3'b010, 7'b0000000, 0, 5'b01011, 0);
        addVec(2'b10, 3'b011, 7'b0000000, 0, 5'b01100, 0);
        addVec(2'b10, 3'b100, 7'b0000000, 0, 5'b01001, 0);
        addVec(2'b10, 3'b101, 7'b0000000, 0, 5'b00101, 0);
        addVec(2'b10, 3'b110, 7'b0000000, 0, 5'b00001, 0);
        addVec(2'b10, 3'b111, 7'b0000000, 0, 5'b00000, 0);
        addVec(2'b10, 3'b101, 7'b0100000, 0, 5'b01010, 0);
        addVec(2'b10, 3'b100, 7'b0100000, 0, 5'b00010, 1);
        addVec(2'b10, 3'b000, 7'b0010000, 0, 5'b00010, 1);
        addVec(2'b10, 3'b110, 7'b1111111, 1, 5'b00001, 0);
        addVec(2'b10, 3'b011, 7'b1111111, 1, 5'b01100, 0);
        addVec(2'b10, 3'b001, 7'b0100000, 1, 5'b00010, 1);
        addVec(2'b10, 3'b101, 7'b0000001, 1, 5'b00010, 1);
`ifdef ALU_CONTROL_PIPE_MEXT_EN
        addVec(2'b10, 3'b000, 7'b0000001, 0, 5'b10000, 0);
        addVec(2'b10, 3'b011, 7'b0000001, 0, 5'b10011, 0);
        addVec(2'b10, 3'b111, 7'b0000001, 0, 5'b10111, 0);
`else
        addVec(2'b10, 3'b000, 7'b0000001, 0, 5'b00010, 1);
        addVec(2'b10, 3'b100, 7'b0000001, 0, 5'b00010, 1);
`endif
        addVec(2'b10, 3'b010, 7'b0000000, 0, 5'b01011, 0);

        foreach (vecs[i]) begin
            applyStimulus(1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].imm, 0);
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 100) begin
                out_ready = ($urandom_range(0, 3) != 0);
                sbStep(vecs[i].code, vecs[i].ill, acc);
                tries++;
            end
            if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        applyStimulus(0, 2'b00, 3'b000, 7'b0, 0, 0);
        for (int k = 0; k < 200 && sb.size() > 0; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            sbStep(5'b0, 1'b0, acc);
        end
        checkOutput("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
